// File: rtl/draw_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : draw_ctrl
// Desc     : DXYN draw sequencer: reads Vx/Vy, issues one draw-engine request,
//            then writes the collision flag to VF. Define DRAW_CTRL_CLIP_EN for
//            bottom-edge clipping of the row count.
// Revision : 1.0  initial release
// ============================================================================
module draw_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic [15:0] opcode,
    input  logic [15:0] I,
    output logic        ack,
    output logic        err,
    output logic [3:0]  reg_raddr,
    input  logic [7:0]  reg_rdata,
    output logic        reg_we,
    output logic [3:0]  reg_waddr,
    output logic [7:0]  reg_wdata,
    output logic        draw_en,
    output logic [15:0] draw_I,
    output logic [10:0] draw_start_pix,
    output logic [3:0]  draw_nibbles,
    input  logic        draw_busy,
    input  logic        draw_col
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        RD_X      = 3'd1,
        RD_Y      = 3'd2,
        WAIT_IDLE = 3'd3,
        ISSUE     = 3'd4,
        WAIT_DONE = 3'd5,
        WR_VF     = 3'd6
    } state_t;

    state_t      state;
    state_t      state_nx;

    logic [7:0]  op_q;
    logic [15:0] base_q;
    logic [5:0]  x_q;
    logic [4:0]  y_q;
    logic        col_acc;
    logic        first_q;

    logic [3:0]  raddr_nx;
    logic [3:0]  waddr_nx;
    logic [7:0]  wdata_nx;
    logic [3:0]  nib_nx;
    logic        ack_nx;
    logic        err_nx;
    logic        we_nx;
    logic        en_nx;

    // Only the low six bits of a register select a pixel position.
    logic        unused_rdata;
    assign unused_rdata = &{1'b0, reg_rdata[7:6]};

`ifdef DRAW_CTRL_CLIP_EN
    logic [5:0]  rows_left;
    assign rows_left = 6'd32 - {1'b0, y_q};

    // y + N > 32 is the same test as N > 32 - y, and avoids a wider adder.
    always_comb begin
        nib_nx = op_q[3:0];
        if ((op_q[3:0] != 4'd0) && ({2'b00, op_q[3:0]} > rows_left)) begin
            nib_nx = rows_left[3:0];
        end
    end
`else
    assign nib_nx = op_q[3:0];
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        raddr_nx = reg_raddr;
        waddr_nx = 4'h0;
        wdata_nx = 8'h00;
        ack_nx   = 1'b0;
        err_nx   = 1'b0;
        we_nx    = 1'b0;
        en_nx    = 1'b0;
        case (state)
            IDLE: begin
                if (req) begin
                    if (opcode[15:12] == 4'hD) begin
                        raddr_nx = opcode[11:8];
                        state_nx = RD_X;
                    end else begin
                        ack_nx = 1'b1;
                        err_nx = 1'b1;
                    end
                end
            end
            RD_X: begin
                raddr_nx = op_q[7:4];
                state_nx = RD_Y;
            end
            RD_Y: begin
                state_nx = WAIT_IDLE;
            end
            WAIT_IDLE: begin
                if (!draw_busy) begin
                    en_nx    = 1'b1;
                    state_nx = ISSUE;
                end
            end
            ISSUE: begin
                state_nx = WAIT_DONE;
            end
            WAIT_DONE: begin
                // The engine may not have raised busy yet in the first cycle.
                if (!first_q && !draw_busy) begin
                    we_nx    = 1'b1;
                    waddr_nx = 4'hF;
                    wdata_nx = {7'b0, col_acc | draw_col};
                    ack_nx   = 1'b1;
                    state_nx = WR_VF;
                end
            end
            WR_VF: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q           <= 8'h00;
            base_q         <= 16'h0000;
            x_q            <= 6'd0;
            y_q            <= 5'd0;
            col_acc        <= 1'b0;
            first_q        <= 1'b0;
            reg_raddr      <= 4'h0;
            reg_we         <= 1'b0;
            reg_waddr      <= 4'h0;
            reg_wdata      <= 8'h00;
            ack            <= 1'b0;
            err            <= 1'b0;
            draw_en        <= 1'b0;
            draw_I         <= 16'h0000;
            draw_start_pix <= 11'd0;
            draw_nibbles   <= 4'h0;
        end else begin
            reg_raddr <= raddr_nx;
            reg_we    <= we_nx;
            reg_waddr <= waddr_nx;
            reg_wdata <= wdata_nx;
            ack       <= ack_nx;
            err       <= err_nx;
            draw_en   <= en_nx;
            if ((state == IDLE) && req) begin
                op_q   <= opcode[7:0];
                base_q <= I;
            end
            if (state == RD_X) begin
                x_q <= reg_rdata[5:0];
            end
            if (state == RD_Y) begin
                y_q <= reg_rdata[4:0];
            end
            if (en_nx) begin
                draw_I         <= base_q;
                draw_start_pix <= {y_q, x_q};
                draw_nibbles   <= nib_nx;
            end
            if (state == ISSUE) begin
                col_acc <= 1'b0;
                first_q <= 1'b1;
            end else if (state == WAIT_DONE) begin
                col_acc <= col_acc | draw_col;
                first_q <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_draw_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_draw_ctrl
// Desc     : Scoreboard bench for draw_ctrl: expected draw requests and
//            completions are queued at stimulus time and popped on draw_en/ack.
// Revision : 1.0  initial release
// ============================================================================
module tb_draw_ctrl;

    logic        clk;
    logic        rst;
    logic        req;
    logic [15:0] opcode;
    logic [15:0] I;
    logic        ack;
    logic        err;
    logic [3:0]  reg_raddr;
    logic [7:0]  reg_rdata;
    logic        reg_we;
    logic [3:0]  reg_waddr;
    logic [7:0]  reg_wdata;
    logic        draw_en;
    logic [15:0] draw_I;
    logic [10:0] draw_start_pix;
    logic [3:0]  draw_nibbles;
    logic        draw_busy;
    logic        draw_col;

    typedef struct {
        logic [15:0] base;
        logic [10:0] pix;
        logic [3:0]  nib;
    } issue_t;

    typedef struct {
        logic        err;
        logic        we;
        logic [7:0]  wdata;
    } done_t;

    issue_t exp_issue[$];
    done_t  exp_done[$];
    issue_t mon_issue;
    issue_t last_issue;
    done_t  mon_done;

    logic [7:0] regs [16];
    int n_checks;
    int n_errors;
    int en_count;
    int ack_count;

    draw_ctrl dut (
        .clk            (clk),
        .rst            (rst),
        .req            (req),
        .opcode         (opcode),
        .I              (I),
        .ack            (ack),
        .err            (err),
        .reg_raddr      (reg_raddr),
        .reg_rdata      (reg_rdata),
        .reg_we         (reg_we),
        .reg_waddr      (reg_waddr),
        .reg_wdata      (reg_wdata),
        .draw_en        (draw_en),
        .draw_I         (draw_I),
        .draw_start_pix (draw_start_pix),
        .draw_nibbles   (draw_nibbles),
        .draw_busy      (draw_busy),
        .draw_col       (draw_col)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register file: data for an address issued at a clock edge is ready in the following cycle.
    assign reg_rdata = regs[reg_raddr];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [3:0] exp_nib(input logic [4:0] y, input logic [3:0] n);
`ifdef DRAW_CTRL_CLIP_EN
        int rows;
        rows = 32 - int'(y);
        if ((n != 4'd0) && (int'(y) + int'(n) > 32)) return rows[3:0];
        return n;
`else
        return (y == 5'd0) ? n : n;
`endif
    endfunction

    always @(negedge clk) begin
        if (!rst) begin
            if (draw_en) begin
                en_count++;
                if (exp_issue.size() == 0) begin
                    check("spurious_en", 32'd1, 32'd0);
                end else begin
                    mon_issue = exp_issue.pop_front();
                    check("draw_I", {16'h0, draw_I}, {16'h0, mon_issue.base});
                    check("draw_pix", {21'h0, draw_start_pix}, {21'h0, mon_issue.pix});
                    check("draw_nib", {28'h0, draw_nibbles}, {28'h0, mon_issue.nib});
                    last_issue = mon_issue;
                end
            end
            if (ack) begin
                ack_count++;
                if (exp_done.size() == 0) begin
                    check("spurious_ack", 32'd1, 32'd0);
                end else begin
                    mon_done = exp_done.pop_front();
                    check("err", {31'h0, err}, {31'h0, mon_done.err});
                    check("reg_we", {31'h0, reg_we}, {31'h0, mon_done.we});
                    if (mon_done.we) begin
                        check("waddr", {28'h0, reg_waddr}, 32'hF);
                        check("wdata", {24'h0, reg_wdata}, {24'h0, mon_done.wdata});
                        check("hold_pix", {21'h0, draw_start_pix}, {21'h0, last_issue.pix});
                        check("hold_nib", {28'h0, draw_nibbles}, {28'h0, last_issue.nib});
                    end
                end
            end else if (reg_we || err) begin
                check("we_err_without_ack", {30'h0, reg_we, err}, 32'h0);
            end
        end
    end

    task automatic do_draw(input logic [15:0] op, input logic [15:0] base,
                           input logic [7:0] vx, input logic [7:0] vy,
                           input int busy_len, input int col_at, input int rel);
        issue_t ei;
        done_t  ed;
        int     cnt;
        int     k;
        int     lim;
        int     en_before;
        bit     seen;
        logic [4:0] y;
        regs[op[11:8]] = vx;
        regs[op[7:4]]  = vy;
        y       = vy[4:0];
        ei.base = base;
        ei.pix  = {y, vx[5:0]};
        ei.nib  = exp_nib(y, op[3:0]);
        exp_issue.push_back(ei);
        lim      = (busy_len > 2) ? busy_len : 2;
        ed.err   = 1'b0;
        ed.we    = 1'b1;
        ed.wdata = ((col_at >= 1) && (col_at <= lim)) ? 8'h01 : 8'h00;
        exp_done.push_back(ed);
        en_before = en_count;
        draw_busy = (rel > 0);
        draw_col  = 1'b0;
        req = 1'b1; opcode = op; I = base;
        cnt = 0; seen = 0;
        while (!seen && cnt < 200) begin
            @(negedge clk);
            cnt++;
            if (draw_en) begin
                seen = 1;
            end else begin
                req = 1'b0;
                if ((rel > 10) && (cnt == 10)) begin
                    req = 1'b1; opcode = 16'h6A12;
                end
                if (cnt == rel) draw_busy = 1'b0;
            end
        end
        req = 1'b0;
        check("en_lat", cnt, ((rel + 1) > 4) ? (rel + 1) : 4);
        draw_busy = (busy_len > 0);
        k = 0; seen = 0;
        while (!seen && k < 200) begin
            @(negedge clk);
            k++;
            if (ack) begin
                seen = 1;
            end else begin
                draw_busy = (k < busy_len);
                draw_col  = (k == col_at);
            end
        end
        check("ack_lat", k, lim + 1);
        draw_busy = 1'b0;
        draw_col  = 1'b0;
        @(negedge clk);
        check("ack_pulse", {31'h0, ack}, 32'h0);
        check("en_pulses", en_count - en_before, 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int cnt;
        int en_before;
        int ack_before;
        n_checks = 0; n_errors = 0; en_count = 0; ack_count = 0;
        for (int i = 0; i < 16; i++) regs[i] = 8'h00;
        rst = 1'b1; req = 1'b0; opcode = 16'h0; I = 16'h0;
        draw_busy = 1'b0; draw_col = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_ctrl", {28'h0, draw_en, ack, err, reg_we}, 32'h0);
        check("rst_draw_I", {16'h0, draw_I}, 32'h0);
        check("rst_pix", {21'h0, draw_start_pix}, 32'h0);
        check("rst_addr", {20'h0, reg_raddr, reg_waddr, draw_nibbles}, 32'h0);
        rst = 1'b0;
        @(negedge clk);

        // Basic DXYN with a collision pulse mid-draw.
        do_draw(16'hD125, 16'h0300, 8'h0A, 8'h05, 6, 3, 0);

        // Non-draw opcode: error completion only.
        en_before = en_count;
        exp_done.push_back('{err: 1'b1, we: 1'b0, wdata: 8'h00});
        req = 1'b1; opcode = 16'h6A12; I = 16'h1234;
        @(negedge clk);
        req = 1'b0;
        check("bad_ack", {31'h0, ack}, 32'h1);
        @(negedge clk);
        check("bad_ack_pulse", {31'h0, ack}, 32'h0);
        repeat (5) @(negedge clk);
        check("bad_no_draw", en_count - en_before, 0);

        // Engine busy for 20 cycles of WAIT_IDLE, stray req ignored meanwhile.
        do_draw(16'hD9A3, 16'h0ABC, 8'h11, 8'h07, 4, 0, 23);

        // Wrap of register values, clip-sensitive row count.
        do_draw(16'hD348, 16'h0400, 8'h45, 8'h3E, 3, 0, 0);
        // N = 0 passes through; engine never raises busy.
        do_draw(16'hDAB0, 16'h0555, 8'h21, 8'h1F, 0, 0, 0);
        // Clip boundaries: y + N == 32 and y + N == 33.
        do_draw(16'hD568, 16'h0600, 8'h7F, 8'h18, 2, 1, 0);
        do_draw(16'hD578, 16'h0610, 8'h7F, 8'h19, 5, 5, 0);

        // Reset in WAIT_DONE abandons the instruction.
        regs[1] = 8'h0A; regs[2] = 8'h05;
        exp_issue.push_back('{base: 16'h0300, pix: {5'd5, 6'd10}, nib: exp_nib(5'd5, 4'd5)});
        req = 1'b1; opcode = 16'hD125; I = 16'h0300;
        cnt = 0;
        @(negedge clk);
        req = 1'b0;
        while (!draw_en && cnt < 50) begin
            @(negedge clk);
            cnt++;
        end
        check("rst_test_en_seen", {31'h0, draw_en}, 32'h1);
        draw_busy = 1'b1;
        repeat (3) @(negedge clk);
        check("pre_rst_draw_I", {16'h0, draw_I}, 32'h0300);
        ack_before = ack_count;
        #2 rst = 1'b1;
        #1;
        check("async_rst_ctrl", {28'h0, draw_en, ack, err, reg_we}, 32'h0);
        check("async_rst_draw_I", {16'h0, draw_I}, 32'h0);
        check("async_rst_pix", {21'h0, draw_start_pix}, 32'h0);
        check("async_rst_data", {12'h0, reg_wdata, reg_raddr, reg_waddr, draw_nibbles}, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        draw_busy = 1'b0;
        repeat (6) @(negedge clk);
        check("rst_no_vf", ack_count - ack_before, 0);
        check("rst_queue_empty", exp_issue.size(), 0);

        // Normal operation resumes after reset.
        do_draw(16'hD125, 16'h0300, 8'h0A, 8'h05, 3, 2, 0);

        repeat (3) @(negedge clk);
        check("issue_queue_drained", exp_issue.size(), 0);
        check("done_queue_drained", exp_done.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
